// File: rtl/mlp_sequencer_pkg.sv
// Shared sizes, FSM encoding and the layer-1 requantizer for the MLP sequencer.
// Accumulators are ACC_W-bit signed. Hidden activations are 7-bit magnitudes in a byte.
package mlp_sequencer_pkg;

  localparam int N_IN  = 784;
  localparam int N_HID = 32;
  localparam int N_OUT = 10;
  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_L1_BIAS,
    S_L2,
    S_L2_BIAS,
    S_ARGMAX,
    S_DONE
  } state_t;

  // ReLU followed by saturation to the 0..127 activation range.
  function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] v);
    logic [7:0] r;
    if (v < 0)
      r = 8'd0;
    else if (v > 127)
      r = 8'd127;
    else
      r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/mlp_argmax.sv
// Sequential arg-max: one value per cycle, and i_start marks the first element.
// A strict greater-than is needed to replace the best, so ties keep the lowest index.
module mlp_argmax
  import mlp_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_vld,
  input  logic signed [ACC_W-1:0] i_val,
  input  logic [3:0]              i_idx,
  output logic [3:0]              o_idx
);

  logic signed [ACC_W-1:0] r_best;
  logic [3:0]              r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best <= '0;
      r_idx  <= '0;
    end else if (i_vld && (i_start || (i_val > r_best))) begin
      r_best <= i_val;
      r_idx  <= i_idx;
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/mlp_sequencer.sv
// Two-layer int8 MLP sequencer: 784 streamed pixels -> 32 hidden -> 10 outputs -> arg-max.
// done pulses 45 cycles after the last pixel handshake. Pixels are accepted whenever in L1.
module mlp_sequencer
  import mlp_sequencer_pkg::*;
#(
  parameter int SHIFT1 = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pixel_valid,
  input  logic [7:0]   pixel_data,
  output logic         pixel_ready,
  output logic [1:0]   layer_sel,
  output logic [9:0]   row_idx,
  input  logic [255:0] w1_in,
  input  logic [255:0] b1_in,
  input  logic [79:0]  w2_in,
  input  logic [79:0]  b2_in,
  output logic         busy,
  output logic         done,
  output logic [3:0]   digit
);

  state_t r_state;
  state_t w_next;

  logic [9:0]              r_pix_cnt;
  logic [4:0]              r_row;
  logic signed [ACC_W-1:0] r_acc1 [N_HID];
  logic signed [ACC_W-1:0] r_acc2 [N_OUT];
  logic [7:0]              r_h    [N_HID];
  logic [3:0]              r_digit;

  logic signed [16:0]      w_p1   [N_HID];
  logic signed [ACC_W-1:0] w_s1   [N_HID];
  logic [7:0]              w_h_nxt[N_HID];
  logic signed [16:0]      w_p2   [N_OUT];
  logic [7:0]              w_hrow;
  logic                    w_last_pix;
  logic [3:0]              w_best_idx;

  assign w_last_pix = (r_state == S_L1) && pixel_valid && (r_pix_cnt == 10'(N_IN - 1));
  assign w_hrow     = r_h[r_row];

  // Pixels are zero-extended to 9 bits so the products stay signed.
  always_comb begin
    for (int j = 0; j < N_HID; j++) begin
      w_p1[j]    = 17'($signed({1'b0, pixel_data})) * 17'($signed(w1_in[j*8 +: 8]));
      w_s1[j]    = r_acc1[j] + 32'($signed(b1_in[j*8 +: 8]));
      w_h_nxt[j] = relu_sat(w_s1[j] >>> SHIFT1);
    end
    for (int k = 0; k < N_OUT; k++) begin
      w_p2[k] = 17'($signed({1'b0, w_hrow})) * 17'($signed(w2_in[k*8 +: 8]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    pixel_ready = 1'b0;
    layer_sel   = 2'd0;
    row_idx     = 10'd0;
    busy        = 1'b1;
    done        = 1'b0;
    digit       = r_digit;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_L1;
      end
      S_L1: begin
        pixel_ready = 1'b1;
        layer_sel   = 2'd1;
        row_idx     = r_pix_cnt;
        if (w_last_pix) w_next = S_L1_BIAS;
      end
      S_L1_BIAS: begin
        layer_sel = 2'd1;
        w_next    = S_L2;
      end
      S_L2: begin
        layer_sel = 2'd2;
        row_idx   = {5'd0, r_row};
        if (r_row == 5'(N_HID - 1)) w_next = S_L2_BIAS;
      end
      S_L2_BIAS: begin
        layer_sel = 2'd2;
        w_next    = S_ARGMAX;
      end
      S_ARGMAX: begin
        if (r_row == 5'(N_OUT - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        digit  = w_best_idx;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_cnt <= '0;
      r_row     <= '0;
      r_digit   <= '0;
      for (int j = 0; j < N_HID; j++) begin
        r_acc1[j] <= '0;
        r_h[j]    <= '0;
      end
      for (int k = 0; k < N_OUT; k++) r_acc2[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pix_cnt <= '0;
            r_row     <= '0;
            for (int j = 0; j < N_HID; j++) r_acc1[j] <= '0;
            for (int k = 0; k < N_OUT; k++) r_acc2[k] <= '0;
          end
        end
        S_L1: begin
          if (pixel_valid) begin
            r_pix_cnt <= r_pix_cnt + 10'd1;
            for (int j = 0; j < N_HID; j++) r_acc1[j] <= r_acc1[j] + 32'(w_p1[j]);
          end
        end
        S_L1_BIAS: begin
          r_row <= '0;
          for (int j = 0; j < N_HID; j++) r_h[j] <= w_h_nxt[j];
        end
        S_L2: begin
          r_row <= r_row + 5'd1;
          for (int k = 0; k < N_OUT; k++) r_acc2[k] <= r_acc2[k] + 32'(w_p2[k]);
        end
        S_L2_BIAS: begin
          r_row <= '0;
          for (int k = 0; k < N_OUT; k++)
            r_acc2[k] <= r_acc2[k] + 32'($signed(b2_in[k*8 +: 8]));
        end
        S_ARGMAX: r_row <= r_row + 5'd1;
        S_DONE:   r_digit <= w_best_idx;
        default: ;
      endcase
    end
  end

  // The first ARGMAX cycle (row 0) seeds the running best unconditionally.
  mlp_argmax u_argmax (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_row == 5'd0),
    .i_vld   (r_state == S_ARGMAX),
    .i_val   (r_acc2[r_row[3:0]]),
    .i_idx   (r_row[3:0]),
    .o_idx   (w_best_idx)
  );

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: hand-computed digits, latency, reset and handshake checks.
module tb_mlp_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         pixel_valid = 1'b0;
  logic [7:0]   pixel_data = 8'd0;
  logic         pixel_ready;
  logic [1:0]   layer_sel;
  logic [9:0]   row_idx;
  logic [255:0] w1_in = '0;
  logic [255:0] b1_in = '0;
  logic [79:0]  w2_in = '0;
  logic [79:0]  b2_in = '0;
  logic         busy;
  logic         done;
  logic [3:0]   digit;

  mlp_sequencer #(.SHIFT1(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_ready (pixel_ready),
    .layer_sel   (layer_sel),
    .row_idx     (row_idx),
    .w1_in       (w1_in),
    .b1_in       (b1_in),
    .w2_in       (w2_in),
    .b2_in       (b2_in),
    .busy        (busy),
    .done        (done),
    .digit       (digit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_inf(input string tag, input logic [7:0] pix, input bit gaps,
                         input bit poke, input logic [3:0] exp_dig);
    int cnt;
    int t_last;
    int t_done;
    int budget;
    int k;
    bit tog;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; tog = 1'b0; budget = 0; t_last = 0;
    while (cnt < 784 && budget < 3000) begin
      pixel_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      pixel_data = pix;
      #1;
      if (cnt == 0 && pixel_valid) begin
        check({tag, "/ready"}, 32'(pixel_ready), 32'd1);
        check({tag, "/l1_sel"}, 32'(layer_sel), 32'd1);
        check({tag, "/row0"}, 32'(row_idx), 32'd0);
      end
      if (cnt == 500 && pixel_valid) check({tag, "/row500"}, 32'(row_idx), 32'd500);
      if (pixel_valid && pixel_ready) begin
        cnt++;
        t_last = cyc;
      end
      @(negedge clk);
      budget++;
    end
    pixel_valid = 1'b0;
    check({tag, "/pixels"}, 32'(cnt), 32'd784);
    t_done = -1; budget = 0;
    while (t_done < 0 && budget < 100) begin
      k = cyc - t_last;
      start = poke && (k == 10);
      #1;
      if (k == 1) check({tag, "/bias1_sel"}, 32'(layer_sel), 32'd1);
      if (k == 2) check({tag, "/l2_row0"}, 32'({layer_sel, row_idx}), 32'({2'd2, 10'd0}));
      if (k == 5) check({tag, "/l2_row3"}, 32'({layer_sel, row_idx}), 32'({2'd2, 10'd3}));
      if (k == 40) check({tag, "/argmax_out"}, 32'({busy, layer_sel, row_idx}), 32'({1'b1, 12'd0}));
      if (done) t_done = cyc;
      else begin
        @(negedge clk);
        budget++;
      end
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(t_done - t_last), 32'd45);
    check({tag, "/digit"}, 32'(digit), 32'(exp_dig));
    @(negedge clk);
    #1;
    check({tag, "/after"}, 32'({done, busy, digit}), 32'({2'b00, exp_dig}));
    if (poke) begin
      repeat (5) @(negedge clk);
      #1;
      check({tag, "/no_restart"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n_done;
    #1;
    check("reset_t0", 32'({busy, done, pixel_ready, layer_sel, row_idx, digit}), 32'd0);
    repeat (3) @(negedge clk);
    check("reset_held", 32'({busy, done, pixel_ready, layer_sel, row_idx, digit}), 32'd0);
    rst = 1'b1;

    // zero data, b2 lane 3 = 5 -> digit 3
    b2_in[3*8 +: 8] = 8'd5;
    run_inf("bias3", 8'd0, 1'b0, 1'b0, 4'd3);

    // everything zero -> tie resolves to 0
    b2_in = '0;
    run_inf("tie", 8'd0, 1'b0, 1'b0, 4'd0);

    // saturated hidden layer, acc2[7] = 32*127 = 4064
    w1_in = {32{8'h7f}};
    w2_in = '0;
    w2_in[7*8 +: 8] = 8'd1;
    run_inf("sat", 8'd255, 1'b0, 1'b0, 4'd7);

    // negative layer-1 sums give h = 0; w2 lane 0 would win if ReLU failed
    w1_in = {32{8'hff}};
    w2_in = '0;
    w2_in[0 +: 8] = 8'd127;
    b2_in[9*8 +: 8] = 8'd1;
    run_inf("relu", 8'd200, 1'b0, 1'b0, 4'd9);

    // 784 >>> 7 = 6, acc2[2] = 192 beats b2 lane 5 = 127
    w1_in = {32{8'h01}};
    w2_in = '0;
    w2_in[2*8 +: 8] = 8'd1;
    b2_in = '0;
    b2_in[5*8 +: 8] = 8'd127;
    run_inf("shift", 8'd1, 1'b0, 1'b0, 4'd2);

    // saturated case again with gapped pixels and a stray start during L2
    w1_in = {32{8'h7f}};
    w2_in = '0;
    w2_in[7*8 +: 8] = 8'd1;
    b2_in = '0;
    run_inf("gaps", 8'd255, 1'b1, 1'b1, 4'd7);

    // asynchronous reset in the middle of L1
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pixel_valid = 1'b1;
    pixel_data = 8'd9;
    repeat (300) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_outputs", 32'({busy, done, pixel_ready, layer_sel, row_idx, digit}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (900) begin
      @(negedge clk);
      if (done) n_done++;
    end
    pixel_valid = 1'b0;
    check("midrst_no_done", 32'(n_done), 32'd0);
    check("midrst_idle", 32'({busy, pixel_ready}), 32'd0);

    // block still works after the abort
    w1_in = '0;
    w2_in = '0;
    b2_in[3*8 +: 8] = 8'd5;
    run_inf("post_rst", 8'd0, 1'b0, 1'b0, 4'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mlp_sequencer.md
MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 SHALL have parameter SHIFT1, default 7: right-shift applied to layer-1 sums before requantization.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin an inference; honoured only in IDLE.
REQ-005 SHALL have port pixel_valid, input, 1: pixel_data is valid this cycle.
REQ-006 SHALL have port pixel_data, input, 8: unsigned pixel value.
REQ-007 SHALL have port pixel_ready, output, 1: pixel is accepted on the same cycle that pixel_valid is high.
REQ-008 SHALL have port layer_sel, output, 2: layer select to the weight memory (0 idle, 1 layer 1, 2 layer 2).
REQ-009 SHALL have port row_idx, output, 10: weight row select to the weight memory.
REQ-010 SHALL have ports w1_in, b1_in (input, 256) and w2_in, b2_in (input, 80): packed signed int8 lanes from the weight memory, lane k at bits [k*8 +: 8], valid in the same cycle.
REQ-011 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse) and digit (output, 4, classification result).

Function
REQ-012 SHALL implement the states IDLE, L1, L1_BIAS, L2, L2_BIAS, ARGMAX and DONE.
REQ-013 IDLE SHALL go to L1 on start; entering L1 SHALL clear all accumulators and counters.
REQ-014 L1: pixel_ready=1 and layer_sel=1; row_idx SHALL equal the pixel count (0..783).
REQ-015 On each L1 handshake, acc1[j] += pixel (zero-extended) * w1 lane j for j=0..31.
REQ-016 Each acc1[j] SHALL be 32-bit signed.
REQ-017 Cycles without pixel_valid SHALL leave acc1 and the pixel count unchanged.
REQ-018 After the 784th handshake, the block SHALL go to L1_BIAS.
REQ-019 L1_BIAS (1 cycle, layer_sel=1): h[j] = clamp((acc1[j] + b1 lane j) >>> SHIFT1, 0, 127), where the shift is arithmetic, negative values give 0 (ReLU), and h is stored as 8-bit unsigned.
REQ-020 L2: layer_sel=2 and row_idx = hidden index 0..31, one row per cycle; acc2[k] += h[row] * w2 lane k for k=0..9.
REQ-021 Each acc2[k] SHALL be 32-bit signed.
REQ-022 The block SHALL leave L2 after exactly 32 cycles.
REQ-023 L2_BIAS (1 cycle, layer_sel=2): acc2[k] += b2 lane k (sign-extended).
REQ-024 ARGMAX (10 cycles): compare acc2[0..9] sequentially, one per cycle; a strict greater-than updates the best value, so ties resolve to the lowest index.
REQ-025 DONE (1 cycle): done=1 and digit latched; the block SHALL then return to IDLE.
REQ-026 digit SHALL hold its value until the next DONE.
REQ-027 Latency: if the last pixel handshake is at cycle T, done=1 at cycle T+45.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 pixel_ready SHALL be 0 outside L1; pixel_valid outside L1 SHALL be ignored.
REQ-031 layer_sel SHALL be 0 and row_idx SHALL be 0 in IDLE, ARGMAX and DONE.

Reset
REQ-032 While rst=0: state=IDLE; busy, done, pixel_ready, layer_sel, row_idx, digit, all accumulators, h and counters SHALL be 0.
REQ-033 Reset asserted mid-inference SHALL abort the inference with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-034 Shared package SHALL hold N_IN=784, N_HID=32, N_OUT=10, ACC_W=32 and the state encoding.
REQ-035 One sub-module, mlp_argmax, SHALL hold the sequential 10-way compare, with ports for start, value stream, index and result.

Verification
REQ-036 Drive rst=0 mid-stream -> all outputs 0 in the same cycle (asynchronous reset); no done after release.
REQ-037 Stimulus: 784 zero pixels; w1, b1, w2 all 0; b2 lane 3 = 5 and other lanes 0 -> digit=3, done exactly 45 cycles after the last pixel.
REQ-038 Stimulus: all weights and biases 0 -> tie resolves to digit=0.
REQ-039 Stimulus: pixels 255, w1 all 127, b1 0 -> h=127 (saturated); w2 lane 7 = 1 and others 0 -> acc2[7]=4064, digit=7.
REQ-040 Stimulus: w1 all -1, pixels 200 -> h all 0 (ReLU); b2 lane 9 = 1 and others 0 -> digit=9.
REQ-041 Stimulus: pixel_valid toggled every other cycle, plus a start pulse during L2 -> result identical to the gapless run, and the extra start is ignored.
